// File: rtl/kanade_bus_pkg.sv
// rtl/kanade_bus_pkg.sv - shared encodings and constants for the kanade bus responder
package kanade_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0]  OFF_GPIO  = 2'd0;
    localparam logic [1:0]  OFF_CYCLE = 2'd1;
    localparam logic [1:0]  OFF_ID    = 2'd2;

    localparam logic [31:0] KANADE_ID         = 32'h4B41_4E41;
    localparam logic [29:0] DEFAULT_MMIO_BASE = 30'h3FFF_FF00;

endpackage

// File: rtl/kanade_sync_ram.sv
// rtl/kanade_sync_ram.sv - single-port synchronous RAM with registered read data
// Ports: clk clock; addr word index; wren write strobe; wdata write word;
//        q word at addr as sampled on the previous rising edge (read-before-write)
module kanade_sync_ram #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic                         wren,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  q
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/kanade_bus_responder.sv
// rtl/kanade_bus_responder.sv - valid/ready memory responder decoding RAM, MMIO and unmapped space
// Ports: clk, reset (sync, active-high);
//        req_valid/req_ready/req_addr/req_we/req_wdata request handshake (word address);
//        rsp_valid/rsp_rdata/rsp_err one-cycle response strobe with data and error;
//        gpio_out GPIO output register
module kanade_bus_responder
    import kanade_bus_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [29:0] MMIO_BASE   = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] gpio_out
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q;
    logic [29:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] cycle_cnt_q;
    logic [31:0] gpio_q;
    logic [31:0] mmio_rdata_q;
    logic        ram_rd_q;
    logic        err_q;

    logic        accept;
    logic        enter_resp;
    logic [29:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_off;
    logic        hit_ram;
    logic        hit_mmio;
    logic        ram_wren;
    logic [31:0] ram_q;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_ready && req_valid;
    assign enter_resp = (state_d == ST_RESP);

    // With zero wait states the RESP-entry edge is the acceptance edge, so the
    // transaction being completed comes straight from the request port while
    // IDLE and from the latched copy otherwise.
    always_comb begin
        cur_addr  = addr_q;
        cur_we    = we_q;
        cur_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_addr  = req_addr;
            cur_we    = req_we;
            cur_wdata = req_wdata;
        end
    end

    assign cur_off  = cur_addr[1:0];
    assign hit_ram  = (cur_addr < 30'(MEM_WORDS));
    assign hit_mmio = (cur_addr[29:2] == MMIO_BASE[29:2]) && (cur_off != 2'd3);

    // Reset on the commit edge aborts the transaction, so the write is gated too.
    assign ram_wren = enter_resp && hit_ram && cur_we && !reset;

    kanade_sync_ram #(
        .MEM_WORDS(MEM_WORDS)
    ) u_ram (
        .clk  (clk),
        .addr (cur_addr[AW-1:0]),
        .wren (ram_wren),
        .wdata(cur_wdata),
        .q    (ram_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            cycle_cnt_q  <= 32'd0;
            gpio_q       <= 32'd0;
            mmio_rdata_q <= 32'd0;
            ram_rd_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_q + 32'd1;

            if (accept) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end

            // Response registers are zero except during RESP.
            mmio_rdata_q <= 32'd0;
            ram_rd_q     <= 1'b0;
            err_q        <= 1'b0;

            if (enter_resp) begin
                err_q    <= !(hit_ram || hit_mmio);
                ram_rd_q <= hit_ram && !cur_we;
                if (hit_mmio && !cur_we) begin
                    case (cur_off)
                        OFF_GPIO:  mmio_rdata_q <= gpio_q;
                        OFF_CYCLE: mmio_rdata_q <= cycle_cnt_q;
                        OFF_ID:    mmio_rdata_q <= KANADE_ID;
                        default:   mmio_rdata_q <= 32'd0;
                    endcase
                end
                if (hit_mmio && cur_we && (cur_off == OFF_GPIO)) begin
                    gpio_q <= cur_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = ram_rd_q ? ram_q : mmio_rdata_q;
    assign rsp_err   = err_q;
    assign gpio_out  = gpio_q;

endmodule
